// File: rtl/cpu_test_sequencer.sv
// Test sequencer: holds a CPU in reset, streams a stimulus table out over a UART, then checks the response bytes.
// Optional build macro SEQ_STALL_INJECT_EN enables periodic CpuStall pulses during the run phase.
module cpu_test_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int STIM_DEPTH   = 16,
    parameter int EXP_DEPTH    = 16,
    parameter int RESET_CYCLES = 30,
    parameter int RUN_CYCLES   = 1000,
    parameter int STALL_PERIOD = 8
) (
    input  logic                                                          Clock,
    input  logic                                                          Reset,
    input  logic                                                          Start,
    input  logic                                                          LoadWe,
    input  logic                                                          LoadSel,
    input  logic [$clog2((STIM_DEPTH > EXP_DEPTH) ? STIM_DEPTH : EXP_DEPTH)-1:0] LoadAddr,
    input  logic [DATA_WIDTH-1:0]                                         LoadData,
    input  logic [$clog2(STIM_DEPTH):0]                                   StimCount,
    input  logic [$clog2(EXP_DEPTH):0]                                    ExpCount,
    output logic                                                          CpuReset,
    output logic                                                          CpuStall,
    output logic [DATA_WIDTH-1:0]                                         DataIn,
    output logic                                                          DataInValid,
    input  logic                                                          DataInReady,
    input  logic [DATA_WIDTH-1:0]                                         DataOut,
    input  logic                                                          DataOutValid,
    output logic                                                          DataOutReady,
    output logic                                                          Busy,
    output logic                                                          Done,
    output logic                                                          Pass,
    output logic [7:0]                                                    ErrCount,
    output logic [$clog2(EXP_DEPTH):0]                                    RxCount
);

    localparam int SAW = $clog2(STIM_DEPTH);
    localparam int EAW = $clog2(EXP_DEPTH);
    localparam int SCW = SAW + 1;
    localparam int ECW = EAW + 1;
    localparam int HCW = $clog2(RESET_CYCLES + 1);
    localparam int TCW = $clog2(RUN_CYCLES + 1);

    generate
        if (DATA_WIDTH < 1 || STIM_DEPTH < 2 || EXP_DEPTH < 2 || RESET_CYCLES < 1 ||
            RUN_CYCLES < 1 || STALL_PERIOD < 2) begin : g_bad_params
            $error("cpu_test_sequencer: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_SEND,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [1:0]              rst_pipe;
    logic                    rst_n;
    logic [DATA_WIDTH-1:0]   stim_mem [STIM_DEPTH];
    logic [DATA_WIDTH-1:0]   exp_mem  [EXP_DEPTH];
    logic [HCW-1:0]          hold_cnt;
    logic [TCW-1:0]          run_cnt;
    logic [TCW-1:0]          run_cnt_next;
    logic [SCW-1:0]          idx;
    logic [SCW-1:0]          idx_inc;
    logic                    send_last;
    logic                    rx_accept;
    logic                    rx_expected;
    logic                    rx_error;
    logic [DATA_WIDTH-1:0]   exp_byte;
    logic [7:0]              err_next;
    logic [ECW-1:0]          rx_next;
    logic                    run_exit;
    logic                    stall_now;

    // Assert asynchronously, release after two clock edges.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_n = rst_pipe[1];

    // Tables have no reset so their contents survive a mid-run reset.
    always_ff @(posedge Clock) begin
        if (LoadWe && !LoadSel && (int'(LoadAddr) < STIM_DEPTH)) begin
            stim_mem[LoadAddr[SAW-1:0]] <= LoadData;
        end
        if (LoadWe && LoadSel && (int'(LoadAddr) < EXP_DEPTH)) begin
            exp_mem[LoadAddr[EAW-1:0]] <= LoadData;
        end
    end

    always_comb begin
        rx_accept   = DataOutValid && DataOutReady;
        rx_expected = (RxCount < ExpCount) && (RxCount < ECW'(EXP_DEPTH));
        exp_byte    = exp_mem[RxCount[EAW-1:0]];
        rx_error    = !rx_expected || (exp_byte != DataOut);

        err_next = ErrCount;
        if (rx_accept && rx_error && (ErrCount != 8'hFF)) begin
            err_next = ErrCount + 8'd1;
        end
        rx_next = RxCount;
        if (rx_accept && (RxCount != '1)) begin
            rx_next = RxCount + 1'b1;
        end

        run_cnt_next = run_cnt;
        if (!stall_now && (run_cnt != TCW'(RUN_CYCLES))) begin
            run_cnt_next = run_cnt + 1'b1;
        end

        // Early exit is level-based on the count, so ExpCount=0 only ends on timeout
        // and surplus bytes taken during SEND end the run on its first cycle.
        run_exit = (state == S_RUN) &&
                   ((run_cnt_next == TCW'(RUN_CYCLES)) ||
                    ((ExpCount != '0) && (rx_next >= ExpCount)));

        idx_inc   = idx + 1'b1;
        send_last = (idx_inc == StimCount);
    end

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            CpuReset     <= 1'b1;
            DataIn       <= '0;
            DataInValid  <= 1'b0;
            DataOutReady <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Pass         <= 1'b0;
            ErrCount     <= '0;
            RxCount      <= '0;
            hold_cnt     <= '0;
            run_cnt      <= '0;
            idx          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                        Busy     <= 1'b1;
                        CpuReset <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HCW'(RESET_CYCLES - 1)) begin
                        state        <= S_SEND;
                        CpuReset     <= 1'b0;
                        run_cnt      <= '0;
                        idx          <= '0;
                        DataIn       <= stim_mem[0];
                        DataInValid  <= (StimCount != '0);
                        DataOutReady <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    run_cnt  <= run_cnt_next;
                    ErrCount <= err_next;
                    RxCount  <= rx_next;
                    if (!DataInValid) begin
                        state <= S_RUN;
                    end else if (DataInReady) begin
                        if (send_last) begin
                            DataInValid <= 1'b0;
                            state       <= S_RUN;
                        end else begin
                            idx    <= idx_inc;
                            DataIn <= stim_mem[idx_inc[SAW-1:0]];
                        end
                    end
                end
                S_RUN: begin
                    run_cnt  <= run_cnt_next;
                    ErrCount <= err_next;
                    RxCount  <= rx_next;
                    if (run_exit) begin
                        state        <= S_DONE;
                        DataOutReady <= 1'b0;
                        Busy         <= 1'b0;
                        Done         <= 1'b1;
                        Pass         <= (err_next == 8'd0) && (rx_next == ExpCount);
                    end
                end
                S_DONE: begin
                    if (Start) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                        CpuReset <= 1'b1;
                        Busy     <= 1'b1;
                        Done     <= 1'b0;
                        Pass     <= 1'b0;
                        ErrCount <= '0;
                        RxCount  <= '0;
                        idx      <= '0;
                        run_cnt  <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_STALL_INJECT_EN
    localparam int SPW = $clog2(STALL_PERIOD);

    logic [SPW-1:0] stall_cnt;
    logic           stall_q;

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            stall_q   <= 1'b0;
        end else if ((state == S_RUN) && !run_exit) begin
            if (stall_cnt == SPW'(STALL_PERIOD - 1)) begin
                stall_cnt <= '0;
                stall_q   <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
                stall_q   <= 1'b0;
            end
        end else begin
            stall_cnt <= '0;
            stall_q   <= 1'b0;
        end
    end
    assign stall_now = stall_q;
`else
    assign stall_now = 1'b0;
`endif

    assign CpuStall = stall_now;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench for cpu_test_sequencer: hold/timeout timing, send handshake, response checking, mid-run reset.
// Expected timeout and stall counts follow SEQ_STALL_INJECT_EN with STALL_PERIOD=4.
module tb_cpu_test_sequencer;

`ifdef SEQ_STALL_INJECT_EN
    localparam int EXP_RUN_LEN = 1332;
    localparam int EXP_STALLS  = 332;
`else
    localparam int EXP_RUN_LEN = 1000;
    localparam int EXP_STALLS  = 0;
`endif

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic       LoadWe;
    logic       LoadSel;
    logic [3:0] LoadAddr;
    logic [7:0] LoadData;
    logic [4:0] StimCount;
    logic [4:0] ExpCount;
    logic       CpuReset;
    logic       CpuStall;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady;
    logic       Busy;
    logic       Done;
    logic       Pass;
    logic [7:0] ErrCount;
    logic [4:0] RxCount;

    int n_checks = 0;
    int n_fails  = 0;

    cpu_test_sequencer #(
        .DATA_WIDTH  (8),
        .STIM_DEPTH  (16),
        .EXP_DEPTH   (16),
        .RESET_CYCLES(30),
        .RUN_CYCLES  (1000),
        .STALL_PERIOD(4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .LoadWe      (LoadWe),
        .LoadSel     (LoadSel),
        .LoadAddr    (LoadAddr),
        .LoadData    (LoadData),
        .StimCount   (StimCount),
        .ExpCount    (ExpCount),
        .CpuReset    (CpuReset),
        .CpuStall    (CpuStall),
        .DataIn      (DataIn),
        .DataInValid (DataInValid),
        .DataInReady (DataInReady),
        .DataOut     (DataOut),
        .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady),
        .Busy        (Busy),
        .Done        (Done),
        .Pass        (Pass),
        .ErrCount    (ErrCount),
        .RxCount     (RxCount)
    );

    always #5 Clock = ~Clock;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        LoadWe   = 1'b1;
        LoadSel  = sel;
        LoadAddr = addr;
        LoadData = data;
        tick();
        LoadWe = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_cpu_reset"}, CpuReset, 1);
        check_value({tag, "_cpu_stall"}, CpuStall, 0);
        check_value({tag, "_in_valid"}, DataInValid, 0);
        check_value({tag, "_out_ready"}, DataOutReady, 0);
        check_value({tag, "_busy"}, Busy, 0);
        check_value({tag, "_done"}, Done, 0);
        check_value({tag, "_pass"}, Pass, 0);
        check_value({tag, "_err"}, ErrCount, 0);
        check_value({tag, "_rx"}, RxCount, 0);
    endtask

    // Counts HOLD cycles; a Start pulse is injected at cycle index 'poke' (negative: none).
    task automatic wait_hold(input int poke, output int len);
        len = 0;
        while (CpuReset && len < 200) begin
            Start = (len == poke);
            len++;
            tick();
        end
        Start = 1'b0;
    endtask

    task automatic send_rx(input string tag, input logic [7:0] b);
        int  n   = 0;
        logic acc = 1'b0;
        DataOut      = b;
        DataOutValid = 1'b1;
        while (!acc && n < 50) begin
            acc = DataOutReady;
            tick();
            n++;
        end
        DataOutValid = 1'b0;
        check_value({tag, "_accepted"}, acc, 1);
    endtask

    // Releases DataInReady and records every byte handed over until Valid drops.
    task automatic drain_tx(output logic [7:0] b0, output logic [7:0] b1, output int cnt);
        int n = 0;
        cnt = 0;
        b0  = '0;
        b1  = '0;
        DataInReady = 1'b1;
        while (DataInValid && n < 40) begin
            if (cnt == 0) b0 = DataIn;
            if (cnt == 1) b1 = DataIn;
            cnt++;
            n++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         len;
        int         run_len;
        int         stalls;
        int         valid_seen;
        int         ready_seen;
        int         cnt;
        logic       stable;
        logic [7:0] b0;
        logic [7:0] b1;

        Reset        = 1'b0;
        Start        = 1'b0;
        LoadWe       = 1'b0;
        LoadSel      = 1'b0;
        LoadAddr     = '0;
        LoadData     = '0;
        StimCount    = '0;
        ExpCount     = '0;
        DataInReady  = 1'b1;
        DataOut      = '0;
        DataOutValid = 1'b0;

        // Reset state, then empty run: hold length and pure timeout.
        repeat (3) tick();
        check_reset_outputs("por");
        Reset = 1'b1;
        repeat (3) tick();
        check_value("idle_busy", Busy, 0);
        pulse_start();
        check_value("hold_busy", Busy, 1);
        wait_hold(-1, len);
        check_value("hold_len", len, 30);
        run_len = 0; stalls = 0; valid_seen = 0; ready_seen = 0;
        while (!Done && run_len < 5000) begin
            if (CpuStall) stalls++;
            if (DataInValid) valid_seen++;
            if (DataOutReady) ready_seen++;
            run_len++;
            tick();
        end
        check_value("timeout_len", run_len, EXP_RUN_LEN);
        check_value("stall_pulses", stalls, EXP_STALLS);
        check_value("empty_valid", valid_seen, 0);
        check_value("run_out_ready", ready_seen, EXP_RUN_LEN);
        check_value("t1_done", Done, 1);
        check_value("t1_pass", Pass, 1);
        check_value("t1_busy", Busy, 0);
        check_value("t1_out_ready", DataOutReady, 0);
        check_value("t1_stall_done", CpuStall, 0);

        // Send handshake with back-pressure, then matching responses.
        load(1'b0, 4'd0, 8'h41);
        load(1'b0, 4'd1, 8'h42);
        load(1'b1, 4'd0, 8'h10);
        load(1'b1, 4'd1, 8'h20);
        StimCount   = 5'd2;
        ExpCount    = 5'd2;
        DataInReady = 1'b0;
        pulse_start();
        check_value("t2_done_cleared", Done, 0);
        wait_hold(-1, len);
        check_value("t2_hold_len", len, 30);
        check_value("t2_valid", DataInValid, 1);
        check_value("t2_first_byte", DataIn, 8'h41);
        stable = 1'b1;
        repeat (5) begin
            if (DataIn !== 8'h41 || DataInValid !== 1'b1) stable = 1'b0;
            tick();
        end
        check_value("t2_stall_stable", stable, 1);
        drain_tx(b0, b1, cnt);
        check_value("t2_tx_count", cnt, 2);
        check_value("t2_tx_b0", b0, 8'h41);
        check_value("t2_tx_b1", b1, 8'h42);
        check_value("t2_run_busy", Busy, 1);
        check_value("t2_run_out_ready", DataOutReady, 1);
        check_value("t2_run_done", Done, 0);
        send_rx("t2_rx0", 8'h10);
        check_value("t2_not_done_yet", Done, 0);
        send_rx("t2_rx1", 8'h20);
        check_value("t2_done_early", Done, 1);
        check_value("t2_pass", Pass, 1);
        check_value("t2_err", ErrCount, 0);
        check_value("t2_rx", RxCount, 2);

        // Mismatch followed by a surplus byte, both taken during SEND.
        load(1'b1, 4'd0, 8'h10);
        StimCount   = 5'd1;
        ExpCount    = 5'd1;
        DataInReady = 1'b0;
        pulse_start();
        check_value("t3_err_cleared", ErrCount, 0);
        check_value("t3_rx_cleared", RxCount, 0);
        wait_hold(-1, len);
        send_rx("t3_rx0", 8'h11);
        send_rx("t3_rx1", 8'h12);
        DataInReady = 1'b1;
        cnt = 0;
        while (!Done && cnt < 20) begin
            cnt++;
            tick();
        end
        check_value("t3_done", Done, 1);
        check_value("t3_err", ErrCount, 2);
        check_value("t3_rx", RxCount, 2);
        check_value("t3_pass", Pass, 0);

        // Reset in the middle of SEND; tables must survive.
        StimCount   = 5'd2;
        ExpCount    = 5'd2;
        DataInReady = 1'b0;
        pulse_start();
        wait_hold(-1, len);
        tick();
        check_value("t4_in_send", DataInValid, 1);
        Reset = 1'b0;
        #1;
        check_reset_outputs("midrun");
        tick();
        Reset = 1'b1;
        repeat (3) tick();
        check_value("t4_idle_valid", DataInValid, 0);
        check_value("t4_idle_busy", Busy, 0);
        pulse_start();
        wait_hold(5, len);
        check_value("t4_start_ignored_hold", len, 30);
        drain_tx(b0, b1, cnt);
        check_value("t4_tx_count", cnt, 2);
        check_value("t4_tx_b0", b0, 8'h41);
        check_value("t4_tx_b1", b1, 8'h42);
        send_rx("t4_rx0", 8'h10);
        send_rx("t4_rx1", 8'h20);
        check_value("t4_done", Done, 1);
        check_value("t4_pass", Pass, 1);
        check_value("t4_err", ErrCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
